// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: active-low segment
// patterns (bit6 = a ... bit0 = g) for nibbles 0..F, plus the blank and
// dash patterns used by the scan driver and decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  // Index n holds the pattern for nibble n (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0001100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seg7_decode.sv
// Purpose: nibble to active-low 7-segment pattern, hex letters or dash for 10..15.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: i_nibble (value to show), i_hex_en (1 = A..F, 0 = dash for 10..15),
//        o_seg (active-low segments, bit6 = a ... bit0 = g).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_en,
  output logic [6:0] o_seg
);

  assign o_seg = (!i_hex_en && (i_nibble > 4'd9)) ? SEG_DASH : SEG_LUT[i_nibble];

endmodule

// File: rtl/segmentos_7_scan.sv
// Purpose: time-multiplexed N-digit common-anode 7-segment driver with frame snapshot.
// Latency: outputs are registered, one clock after the (idx, cnt, snapshot) state.
// Backpressure: none; enable = 0 darkens the display and freezes the scan position.
// Ports: clk, rst (async active-high); data_in (nibble k -> digit k), dp_in,
//        blank_lz, enable; segments_out/dp_out/digit_sel (all active-low),
//        frame_start (one-cycle pulse after each snapshot).
module segmentos_7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 1,
  parameter int HEX_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [6:0]            segments_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;

  // Frame snapshot
  logic [4*N_DIGITS-1:0] r_snap_data;
  logic [N_DIGITS-1:0]   r_snap_dp;
  logic                  r_snap_blz;

  // Output registers
  logic [6:0]          r_seg;
  logic                r_dp_out;
  logic [N_DIGITS-1:0] r_sel;
  logic                r_fs;

  logic                w_start;
  logic [3:0]          w_nib;
  logic                w_dp_bit;
  logic                w_blank;
  logic                w_upper_zero;
  logic [6:0]          w_dec_seg;
  logic [N_DIGITS-1:0] w_sel;
  logic                w_hex_en;

  assign w_hex_en = (HEX_EN != 0);
  // A frame begins at the very first clock of digit 0's slot.
  assign w_start  = enable && (r_idx == '0) && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (enable) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_data <= '0;
      r_snap_dp   <= '0;
      r_snap_blz  <= 1'b0;
    end else if (w_start) begin
      r_snap_data <= data_in;
      r_snap_dp   <= dp_in;
      r_snap_blz  <= blank_lz;
    end
  end

  // Walk digits from most significant down so w_upper_zero, at digit k,
  // means "nibble k and every nibble above it are zero".
  always_comb begin
    w_nib        = 4'h0;
    w_dp_bit     = 1'b0;
    w_blank      = 1'b0;
    w_upper_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_upper_zero = w_upper_zero && (r_snap_data[4*k +: 4] == 4'h0);
      if (r_idx == IDX_W'(k)) begin
        w_nib    = r_snap_data[4*k +: 4];
        w_dp_bit = r_snap_dp[k];
        w_blank  = r_snap_blz && (k != 0) && w_upper_zero;
      end
    end
  end

  always_comb begin
    w_sel = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_sel[k] = (r_idx != IDX_W'(k));
    end
  end

  seg7_decode u_decode (
    .i_nibble (w_nib),
    .i_hex_en (w_hex_en),
    .o_seg    (w_dec_seg)
  );

  // The guard window at the start of every slot keeps all anodes off so the
  // previous digit's pattern cannot ghost onto the next digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg    <= SEG_OFF;
      r_dp_out <= 1'b1;
      r_sel    <= '1;
      r_fs     <= 1'b0;
    end else begin
      r_fs <= w_start;
      if (!enable || (r_cnt < CNT_GUARD)) begin
        r_seg    <= SEG_OFF;
        r_dp_out <= 1'b1;
        r_sel    <= '1;
      end else begin
        r_seg    <= w_blank ? SEG_OFF : w_dec_seg;
        r_dp_out <= ~w_dp_bit;
        r_sel    <= w_sel;
      end
    end
  end

  assign segments_out = r_seg;
  assign dp_out       = r_dp_out;
  assign digit_sel    = r_sel;
  assign frame_start  = r_fs;

endmodule

// File: tb/tb_segmentos_7_scan.sv
// Bench for segmentos_7_scan (4 digits, 4-clock slots, 1-clock guard).
// A frame-position reference model predicts every output cycle and queues it;
// a monitor on the falling edge pops and compares. A second instance with
// hex decode disabled shares the stimulus to cover the dash patterns.
module tb_segmentos_7_scan;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int GD    = 1;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b0;

  logic [6:0] segments_out, segments_nh;
  logic       dp_out, dp_nh;
  logic [3:0] digit_sel, sel_nh;
  logic       frame_start, fs_nh;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  segmentos_7_scan #(.N_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .HEX_EN(1)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .enable(enable), .segments_out(segments_out), .dp_out(dp_out),
    .digit_sel(digit_sel), .frame_start(frame_start)
  );

  segmentos_7_scan #(.N_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .HEX_EN(0)) u_dut_nh (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .enable(enable), .segments_out(segments_nh), .dp_out(dp_nh),
    .digit_sel(sel_nh), .frame_start(fs_nh)
  );

  typedef struct {
    logic [6:0] seg;
    logic [6:0] seg_nh;
    logic       dp;
    logic [3:0] sel;
    logic       fs;
  } exp_t;

  exp_t q[$];

  // Reference model: position within the frame as a single integer
  int          m_pos = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;
  logic        m_blz = 1'b0;

  function automatic logic [6:0] ref_glyph(input logic [3:0] n, input bit hex);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0001100;
      4'hA: return hex ? 7'b0001000 : 7'b1111110;
      4'hB: return hex ? 7'b1100000 : 7'b1111110;
      4'hC: return hex ? 7'b0110001 : 7'b1111110;
      4'hD: return hex ? 7'b1000010 : 7'b1111110;
      4'hE: return hex ? 7'b0110000 : 7'b1111110;
      default: return hex ? 7'b0111000 : 7'b1111110;
    endcase
  endfunction

  // A reset edge while the clock is low is the asynchronous event; a clock
  // edge (clock high) produces one expected output cycle.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    int   d, w;
    logic [15:0] upper;
    logic [3:0]  nib;
    if (rst && !clk) begin
      q.delete();
      m_pos = 0; m_data = '0; m_dp = '0; m_blz = 1'b0;
    end else begin
      e.seg = 7'h7F; e.seg_nh = 7'h7F; e.dp = 1'b1; e.sel = 4'hF; e.fs = 1'b0;
      if (rst) begin
        m_pos = 0; m_data = '0; m_dp = '0; m_blz = 1'b0;
      end else if (enable) begin
        d = m_pos / SD;
        w = m_pos % SD;
        e.fs = (m_pos == 0);
        if (w >= GD) begin
          upper = m_data >> (4 * d);
          nib   = upper[3:0];
          e.sel = ~(4'b0001 << d);
          e.dp  = ~m_dp[d];
          if (m_blz && d > 0 && upper == 16'h0) begin
            e.seg = 7'h7F; e.seg_nh = 7'h7F;
          end else begin
            e.seg = ref_glyph(nib, 1'b1); e.seg_nh = ref_glyph(nib, 1'b0);
          end
        end
        if (m_pos == 0) begin
          m_data = data_in; m_dp = dp_in; m_blz = blank_lz;
        end
        m_pos = (m_pos + 1) % FRAME;
      end
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (segments_out !== e.seg || segments_nh !== e.seg_nh || dp_out !== e.dp ||
          digit_sel !== e.sel || frame_start !== e.fs) begin
        n_fail++;
        $display("FAIL scan_out t=%0t: got seg=%b seg_nohex=%b dp=%b sel=%b fs=%b, want seg=%b seg_nohex=%b dp=%b sel=%b fs=%b",
                 $time, segments_out, segments_nh, dp_out, digit_sel, frame_start,
                 e.seg, e.seg_nh, e.dp, e.sel, e.fs);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_pos(input int target);
    int k;
    for (k = 0; k < 200; k++) begin
      if (m_pos == target) break;
      cycles(1);
    end
    if (k == 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_pos: frame position %0d never reached, now %0d", target, m_pos);
    end
  endtask

  task automatic check_dark(input string name);
    n_chk++;
    if (segments_out !== 7'h7F || dp_out !== 1'b1 || digit_sel !== 4'hF || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got seg=%b dp=%b sel=%b fs=%b, want seg=1111111 dp=1 sel=1111 fs=0",
               name, segments_out, dp_out, digit_sel, frame_start);
    end
  endtask

  initial begin
    cycles(2);
    check_dark("reset_state");
    rst = 1'b0;

    // Plain decimal value
    enable = 1'b1; data_in = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0;
    cycles(20);

    // Hex digit with leading-zero blanking
    data_in = 16'h00A5; blank_lz = 1'b1;
    cycles(32);

    // All zero: only digit 0 lit, decimal point on digit 2
    data_in = 16'h0000; dp_in = 4'b0100;
    cycles(32);

    // Mid-frame change is held off until the next snapshot
    data_in = 16'h1111; dp_in = 4'b0000; blank_lz = 1'b0;
    cycles(20);
    wait_pos(2 * SD);
    data_in = 16'h2222;
    cycles(24);

    // Pause the scan mid-slot, then resume
    wait_pos(1 * SD + 2);
    enable = 1'b0;
    cycles(10);
    enable = 1'b1;
    cycles(20);

    // Asynchronous reset while digit 3 is lit
    data_in = 16'h9876; dp_in = 4'b1001;
    cycles(16);
    wait_pos(3 * SD + 2);
    #1 rst = 1'b1;
    #1 check_dark("async_reset");
    cycles(2);
    rst = 1'b0;
    cycles(20);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) data_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 11) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blank_lz = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 9) != 0);
      cycles(1);
    end

    enable = 1'b1;
    cycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
